// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - select and strobe bundle between the LCD control unit and its datapath/panel
interface lcd_ctrl_if;
  logic [1:0] init_sel;
  logic [1:0] mux_sel;
  logic       data_sel;
  logic       DB_sel;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       init_done;

  modport master (
    output init_sel, mux_sel, data_sel, DB_sel,
    output LCD_E, LCD_RS, LCD_RW, init_done
  );

  modport slave (
    input init_sel, mux_sel, data_sel, DB_sel,
    input LCD_E, LCD_RS, LCD_RW, init_done
  );
endinterface

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 8-bit init sequencer and line-2 BCD digit refresher
module lcd_ctrl #(
  parameter int PWR_WAIT     = 750000,
  parameter int E_HIGH       = 12,
  parameter int CMD_WAIT     = 2000,
  parameter int CLR_WAIT     = 82000,
  parameter int REFRESH_WAIT = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  lcd_ctrl_if.master lcd
);

  typedef enum logic [2:0] {
    S_PWR,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  localparam int MAX_A    = (PWR_WAIT > REFRESH_WAIT) ? PWR_WAIT : REFRESH_WAIT;
  localparam int MAX_B    = (CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT;
  localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_WAIT = (MAX_C > E_HIGH) ? MAX_C : E_HIGH;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  // The power-up wait also spans the reset-release cycle, so the first E rise
  // lands on edge PWR_WAIT+2; every other wait terminates after exactly N cycles.
  localparam logic [CW-1:0] PWR_T = CW'(PWR_WAIT);
  localparam logic [CW-1:0] E_T   = CW'(E_HIGH - 1);
  localparam logic [CW-1:0] CMD_T = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_T = CW'(CLR_WAIT - 1);
  localparam logic [CW-1:0] REF_T = CW'(REFRESH_WAIT - 1);

  localparam logic [3:0] STEP_CLEAR = 4'd3;
  localparam logic [3:0] STEP_ADDR  = 4'd4;
  localparam logic [3:0] STEP_LAST  = 4'd8;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    step;
  logic [3:0]    step_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wait_t;
  logic          done_set;
  logic          setup_entry;

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    done_set  = 1'b0;
    wait_t    = (step == STEP_CLEAR) ? CLR_T : CMD_T;
    unique case (state)
      S_PWR: begin
        if (cnt == PWR_T) begin
          state_nxt = S_SETUP;
          step_nxt  = 4'd0;
        end
      end
      S_SETUP: state_nxt = S_PULSE;
      S_PULSE: begin
        if (cnt == E_T) state_nxt = S_HOLD;
      end
      S_HOLD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (cnt == wait_t) begin
          done_set = (step == STEP_CLEAR);
          if (step == STEP_LAST) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_SETUP;
            step_nxt  = step + 4'd1;
          end
        end
      end
      S_IDLE: begin
        // Refresh passes restart at the address command; init is never replayed.
        if (cnt == REF_T) begin
          state_nxt = S_SETUP;
          step_nxt  = STEP_ADDR;
        end
      end
      default: begin
        state_nxt = S_PWR;
        step_nxt  = 4'd0;
      end
    endcase
  end

  assign setup_entry = (state_nxt == S_SETUP) && (state != S_SETUP);
  assign lcd.LCD_RW  = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_PWR;
      step          <= 4'd0;
      cnt           <= '0;
      lcd.init_sel  <= 2'd0;
      lcd.mux_sel   <= 2'd0;
      lcd.data_sel  <= 1'b0;
      lcd.DB_sel    <= 1'b1;
      lcd.LCD_E     <= 1'b0;
      lcd.LCD_RS    <= 1'b0;
      lcd.init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      cnt       <= (state_nxt != state) ? '0 : cnt + 1'b1;
      lcd.LCD_E <= (state_nxt == S_PULSE);
      if (done_set) lcd.init_done <= 1'b1;
      // Selects only move here so the byte on DB is settled before E rises
      // and stays put until the next write begins.
      if (setup_entry) begin
        if (step_nxt <= STEP_CLEAR) begin
          lcd.init_sel <= step_nxt[1:0];
          lcd.data_sel <= 1'b0;
          lcd.DB_sel   <= 1'b1;
          lcd.LCD_RS   <= 1'b0;
        end else if (step_nxt == STEP_ADDR) begin
          lcd.DB_sel   <= 1'b0;
          lcd.LCD_RS   <= 1'b0;
        end else begin
          lcd.mux_sel  <= 2'(STEP_LAST - step_nxt);
          lcd.data_sel <= 1'b1;
          lcd.DB_sel   <= 1'b1;
          lcd.LCD_RS   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - scoreboard bench for lcd_ctrl with a behavioural datapath model
module tb_lcd_ctrl;
  localparam int PWR_WAIT     = 10;
  localparam int E_HIGH       = 2;
  localparam int CMD_WAIT     = 5;
  localparam int CLR_WAIT     = 8;
  localparam int REFRESH_WAIT = 20;

  typedef struct {
    logic [7:0] db;
    logic       rs;
    int         rise;
    int         width;
    logic       done;
  } cap_t;

  typedef struct {
    logic [7:0] db;
    logic       rs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] cnt_d [4];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int done_edge = -1;
  int last_rise = 0;
  bit rw_seen = 1'b0;
  bit unstable = 1'b0;

  cap_t cap_q [$];
  exp_t exp_q [$];

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .PWR_WAIT    (PWR_WAIT),
    .E_HIGH      (E_HIGH),
    .CMD_WAIT    (CMD_WAIT),
    .CLR_WAIT    (CLR_WAIT),
    .REFRESH_WAIT(REFRESH_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .lcd  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dp_byte();
    logic [7:0] b;
    if (bus.DB_sel !== 1'b1) begin
      b = 8'hCE;
    end else if (bus.data_sel === 1'b1) begin
      b = {4'b0011, cnt_d[bus.mux_sel]};
    end else begin
      case (bus.init_sel)
        2'd0:    b = 8'h38;
        2'd1:    b = 8'h0C;
        2'd2:    b = 8'h06;
        default: b = 8'h01;
      endcase
    end
    return b;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  logic       e_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic [7:0] db_prev = 8'h00;
  logic       rs_prev = 1'b0;
  cap_t       cur;

  always @(negedge clk) begin
    logic [7:0] db_now;
    db_now = dp_byte();
    if (bus.LCD_RW === 1'b1) rw_seen = 1'b1;
    if (bus.LCD_E === 1'b1 && !e_prev) begin
      cur.db = db_now; cur.rs = bus.LCD_RS; cur.rise = edge_cnt;
      cur.width = 1; cur.done = bus.init_done;
    end else if (bus.LCD_E === 1'b1 && e_prev) begin
      cur.width = cur.width + 1;
      if (db_now !== db_prev || bus.LCD_RS !== rs_prev) unstable = 1'b1;
    end else if (bus.LCD_E !== 1'b1 && e_prev) begin
      cap_q.push_back(cur);
    end
    if (bus.init_done === 1'b1 && !done_prev) done_edge = edge_cnt;
    e_prev    = (bus.LCD_E === 1'b1);
    done_prev = (bus.init_done === 1'b1);
    db_prev   = db_now;
    rs_prev   = bus.LCD_RS;
  end

  task automatic get_cap(output cap_t c, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (cap_q.size() == 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (cap_q.size() != 0) begin
      c = cap_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.LCD_E !== 1'b0) begin errors++; $display("FAIL reset_e got %b want 0", bus.LCD_E); end
    checks++; if (bus.LCD_RS !== 1'b0) begin errors++; $display("FAIL reset_rs got %b want 0", bus.LCD_RS); end
    checks++; if (bus.LCD_RW !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", bus.LCD_RW); end
    checks++; if (bus.DB_sel !== 1'b1) begin errors++; $display("FAIL reset_db_sel got %b want 1", bus.DB_sel); end
    checks++; if (bus.data_sel !== 1'b0) begin errors++; $display("FAIL reset_data_sel got %b want 0", bus.data_sel); end
    checks++; if (bus.init_sel !== 2'd0 || bus.mux_sel !== 2'd0) begin
      errors++; $display("FAIL reset_sels got init %0d mux %0d want 0 0", bus.init_sel, bus.mux_sel);
    end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", bus.init_done); end
    cap_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [7:0] bytes [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    cap_t c;
    exp_t e;
    bit ok;
    int prev_rise = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{bytes[i], 1'b0});
    for (int i = 0; i < 4; i++) begin
      get_cap(c, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL init_timeout pulse %0d got none want pulse", i); return; end
      e = exp_q.pop_front();
      checks++; if (c.db !== e.db || c.rs !== e.rs) begin
        errors++; $display("FAIL init_byte %0d got %h/%b want %h/%b", i, c.db, c.rs, e.db, e.rs);
      end
      checks++; if (c.width !== E_HIGH) begin errors++; $display("FAIL init_width %0d got %0d want %0d", i, c.width, E_HIGH); end
      checks++;
      if (i == 0) begin
        if (c.rise !== PWR_WAIT + 2) begin errors++; $display("FAIL first_rise got edge %0d want %0d", c.rise, PWR_WAIT + 2); end
      end else if (c.rise - prev_rise !== 2 + E_HIGH + CMD_WAIT) begin
        errors++; $display("FAIL init_period %0d got %0d want %0d", i, c.rise - prev_rise, 2 + E_HIGH + CMD_WAIT);
      end
      checks++; if (c.done !== 1'b0) begin errors++; $display("FAIL init_done_early %0d got %b want 0", i, c.done); end
      prev_rise = c.rise;
    end
    last_rise = prev_rise;
  endtask

  task automatic test_digits();
    logic [7:0] bytes [5] = '{8'hCE, 8'h31, 8'h32, 8'h33, 8'h34};
    cap_t c;
    exp_t e;
    bit ok;
    int prev_rise = last_rise;
    for (int i = 0; i < 5; i++) exp_q.push_back('{bytes[i], (i != 0)});
    for (int i = 0; i < 5; i++) begin
      get_cap(c, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL digit_timeout pulse %0d got none want pulse", i); return; end
      e = exp_q.pop_front();
      checks++; if (c.db !== e.db || c.rs !== e.rs) begin
        errors++; $display("FAIL digit_byte %0d got %h/%b want %h/%b", i, c.db, c.rs, e.db, e.rs);
      end
      checks++;
      if (i == 0) begin
        if (c.rise - prev_rise !== 2 + E_HIGH + CLR_WAIT) begin
          errors++; $display("FAIL clear_gap got %0d want %0d", c.rise - prev_rise, 2 + E_HIGH + CLR_WAIT);
        end
        checks++; if (done_edge !== prev_rise + E_HIGH + 1 + CLR_WAIT) begin
          errors++; $display("FAIL init_done_edge got %0d want %0d", done_edge, prev_rise + E_HIGH + 1 + CLR_WAIT);
        end
        checks++; if (c.done !== 1'b1) begin errors++; $display("FAIL init_done_after got %b want 1", c.done); end
      end else if (c.rise - prev_rise !== 2 + E_HIGH + CMD_WAIT) begin
        errors++; $display("FAIL digit_period %0d got %0d want %0d", i, c.rise - prev_rise, 2 + E_HIGH + CMD_WAIT);
      end
      prev_rise = c.rise;
    end
    last_rise = prev_rise;
  endtask

  task automatic test_idle();
    logic [7:0] bytes [5] = '{8'hCE, 8'h31, 8'h32, 8'h33, 8'h39};
    cap_t c;
    exp_t e;
    bit ok;
    repeat (10) @(negedge clk);
    cnt_d[0] = 4'd9;
    for (int i = 0; i < 5; i++) exp_q.push_back('{bytes[i], (i != 0)});
    for (int i = 0; i < 5; i++) begin
      get_cap(c, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL idle_timeout pulse %0d got none want pulse", i); return; end
      e = exp_q.pop_front();
      checks++; if (c.db !== e.db || c.rs !== e.rs) begin
        errors++; $display("FAIL idle_byte %0d got %h/%b want %h/%b", i, c.db, c.rs, e.db, e.rs);
      end
      if (i == 0) begin
        checks++; if (c.rise - last_rise !== 2 + E_HIGH + CMD_WAIT + REFRESH_WAIT) begin
          errors++; $display("FAIL idle_gap got %0d want %0d", c.rise - last_rise, 2 + E_HIGH + CMD_WAIT + REFRESH_WAIT);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    cap_t c;
    bit ok;
    int n = 0;
    while (!(bus.LCD_E === 1'b1 && bus.LCD_RS === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL abort_timeout got no digit pulse want one"); return; end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.LCD_E !== 1'b0) begin errors++; $display("FAIL abort_e got %b want 0", bus.LCD_E); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL abort_init_done got %b want 0", bus.init_done); end
    checks++; if (bus.LCD_RS !== 1'b0 || bus.DB_sel !== 1'b1) begin
      errors++; $display("FAIL abort_sels got rs %b db_sel %b want 0 1", bus.LCD_RS, bus.DB_sel);
    end
    @(negedge clk);
    cap_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    exp_q.push_back('{8'h38, 1'b0});
    get_cap(c, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_timeout got none want pulse"); return; end
    checks++; if (c.db !== exp_q[0].db || c.rs !== exp_q[0].rs) begin
      errors++; $display("FAIL restart_byte got %h/%b want %h/%b", c.db, c.rs, exp_q[0].db, exp_q[0].rs);
    end
    void'(exp_q.pop_front());
    checks++; if (c.rise !== PWR_WAIT + 2) begin errors++; $display("FAIL restart_rise got %0d want %0d", c.rise, PWR_WAIT + 2); end
  endtask

  task automatic test_invariants();
    checks++; if (rw_seen) begin errors++; $display("FAIL rw_high got 1 want 0"); end
    checks++; if (unstable) begin errors++; $display("FAIL db_change_while_e got 1 want 0"); end
  endtask

  initial begin
    cnt_d[3] = 4'd1;
    cnt_d[2] = 4'd2;
    cnt_d[1] = 4'd3;
    cnt_d[0] = 4'd4;
    test_reset();
    test_init();
    test_digits();
    test_idle();
    test_reset_abort();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
